// File: rtl/integral_pkg.sv
// integral_pkg: shared state encoding, width helper and default sizes for the integral row stage.
package integral_pkg;
  typedef enum logic {ST_FILL, ST_RUN} state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SUM_WIDTH = 28;
  localparam int DEF_FRAME_WIDTH = 640;
  localparam int DEF_WINDOW_WIDTH = 24;
  function automatic int addr_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/integral_row_window_line_fifo.sv
// line_fifo: one-line delay FIFO with flush; simultaneous read and write are allowed when full.
module line_fifo import integral_pkg::*; #(
  parameter int W = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FRAME_WIDTH,
  localparam int AW = addr_w(DEPTH),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic [AW-1:0] count
);
  logic [W-1:0] mem_q [2**PW];
  logic [PW-1:0] wp_q, wp_d, wp_b, rp_q, rp_d, rp_b;
  logic [AW-1:0] cnt_q, cnt_d, cnt_b;
  logic do_wr, do_rd;
  always_comb begin
    wp_b = flush ? '0 : wp_q;
    rp_b = flush ? '0 : rp_q;
    cnt_b = flush ? '0 : cnt_q;
    do_rd = rd && cnt_b != '0;
    do_wr = wr && (cnt_b != AW'(DEPTH) || do_rd);
    wp_d = !do_wr ? wp_b : (wp_b == PW'(DEPTH - 1)) ? '0 : wp_b + PW'(1);
    rp_d = !do_rd ? rp_b : (rp_b == PW'(DEPTH - 1)) ? '0 : rp_b + PW'(1);
    cnt_d = (do_wr && !do_rd) ? cnt_b + AW'(1) : (do_rd && !do_wr) ? cnt_b - AW'(1) : cnt_b;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk)
    if (do_wr) mem_q[wp_b] <= wdata;
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/integral_row_window.sv
// integral_row_window: row stage of the integral-image line buffer (row sum, window, one-line pixel delay).
// Define ROW_SAT_EN to saturate the row-sum and integral additions and report it on o_ovf.
module integral_row_window import integral_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH,
  parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
  parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [SUM_WIDTH-1:0]           in_above,
  output logic                           out_valid,
  output logic [SUM_WIDTH-1:0]           out_ii,
  output logic [WINDOW_WIDTH*SUM_WIDTH-1:0] out_window,
  output logic                           out_eol,
  output logic                           out_line_valid,
  output logic [DATA_WIDTH-1:0]          out_line_data,
  output logic                           o_fill,
  output logic                           o_ovf
);
  localparam int AW = addr_w(FRAME_WIDTH);
  state_e state_q, state_d, st_b;
  logic [AW-1:0] col_q, col_d, col_b, cnt_b, fifo_count;
  logic [SUM_WIDTH-1:0] rs_q, rs_d, rs_b, rs_n, ii_n, out_ii_q, out_ii_d;
  logic [SUM_WIDTH-1:0] win_q [WINDOW_WIDTH];
  logic [SUM_WIDTH-1:0] win_d [WINDOW_WIDTH];
  logic [DATA_WIDTH-1:0] line_q, line_d, fifo_rdata;
  logic out_valid_q, out_valid_d, eol_q, eol_d, lv_q, lv_d, fill_done, pop;
  line_fifo #(.W(DATA_WIDTH), .DEPTH(FRAME_WIDTH)) u_fifo (
    .clk(clk), .reset(reset), .flush(in_sof), .wr(in_valid), .wdata(in_data),
    .rd(pop), .rdata(fifo_rdata), .count(fifo_count)
  );
`ifdef ROW_SAT_EN
  logic [SUM_WIDTH:0] rs_x, ii_x;
  logic ovf_q, ovf_d;
  assign rs_x = {1'b0, rs_b} + (SUM_WIDTH + 1)'(in_data);
  assign rs_n = rs_x[SUM_WIDTH] ? '1 : rs_x[SUM_WIDTH-1:0];
  assign ii_x = {1'b0, rs_n} + {1'b0, in_above};
  assign ii_n = ii_x[SUM_WIDTH] ? '1 : ii_x[SUM_WIDTH-1:0];
  assign ovf_d = (!in_sof && ovf_q) || (in_valid && (rs_x[SUM_WIDTH] || ii_x[SUM_WIDTH]));
  always_ff @(posedge clk or posedge reset)
    if (reset) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  assign o_ovf = ovf_q;
`else
  assign rs_n = rs_b + SUM_WIDTH'(in_data);
  assign ii_n = rs_n + in_above;
  assign o_ovf = 1'b0;
`endif
  // sof flushes before the same-cycle sample, so all bases see the flushed state.
  always_comb begin
    col_b = in_sof ? '0 : col_q;
    cnt_b = in_sof ? '0 : fifo_count;
    st_b = in_sof ? ST_FILL : state_q;
    rs_b = (col_b == '0) ? '0 : rs_q;
    fill_done = in_valid && cnt_b == AW'(FRAME_WIDTH - 1);
    pop = in_valid && st_b == ST_RUN;
    state_d = (st_b == ST_FILL && fill_done) ? ST_RUN : st_b;
    col_d = !in_valid ? col_b : (col_b == AW'(FRAME_WIDTH - 1)) ? '0 : col_b + AW'(1);
    rs_d = in_valid ? rs_n : (in_sof ? '0 : rs_q);
    win_d[0] = in_valid ? ii_n : win_q[0];
    for (int k = 1; k < WINDOW_WIDTH; k++) win_d[k] = in_valid ? win_q[k-1] : win_q[k];
    out_ii_d = in_valid ? ii_n : out_ii_q;
    out_valid_d = in_valid && col_b >= AW'(WINDOW_WIDTH - 1);
    eol_d = in_valid && col_b == AW'(FRAME_WIDTH - 1);
    lv_d = pop;
    line_d = pop ? fifo_rdata : line_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_FILL;
      col_q <= '0;
      rs_q <= '0;
      win_q <= '{default: '0};
      out_ii_q <= '0;
      out_valid_q <= 1'b0;
      eol_q <= 1'b0;
      lv_q <= 1'b0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      rs_q <= rs_d;
      win_q <= win_d;
      out_ii_q <= out_ii_d;
      out_valid_q <= out_valid_d;
      eol_q <= eol_d;
      lv_q <= lv_d;
      line_q <= line_d;
    end
  for (genvar k = 0; k < WINDOW_WIDTH; k++) begin : g_win
    assign out_window[k*SUM_WIDTH +: SUM_WIDTH] = win_q[k];
  end
  assign out_ii = out_ii_q;
  assign out_valid = out_valid_q;
  assign out_eol = eol_q;
  assign out_line_valid = lv_q;
  assign out_line_data = line_q;
  assign o_fill = state_q == ST_RUN;
endmodule

// File: tb/tb_integral_row_window.sv
// tb_integral_row_window: directed checks of the row stage with a 4-pixel line and 2-column window.
module tb_integral_row_window;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0] in_data = '0, in_above = '0;
  logic out_valid, out_eol, out_line_valid, o_fill, o_ovf;
  logic [7:0] out_ii, out_line_data;
  logic [15:0] out_window;
  int tests = 0, fails = 0;
  integral_row_window #(.DATA_WIDTH(8), .SUM_WIDTH(8), .FRAME_WIDTH(4), .WINDOW_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_above(in_above), .out_valid(out_valid), .out_ii(out_ii), .out_window(out_window),
    .out_eol(out_eol), .out_line_valid(out_line_valid), .out_line_data(out_line_data),
    .o_fill(o_fill), .o_ovf(o_ovf)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic [7:0] a);
    in_valid = v;
    in_sof = s;
    in_data = d;
    in_above = a;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, out_ii, out_window, out_eol, out_line_valid, out_line_data, o_fill, o_ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ii=%0d win=%h v=%b eol=%b lv=%b ld=%0d fill=%b ovf=%b, want all 0",
               out_ii, out_window, out_valid, out_eol, out_line_valid, out_line_data, o_fill, o_ovf);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_fill;
    logic [7:0] ii_e [4] = '{1, 3, 6, 10};
    logic v_e [4] = '{0, 1, 1, 1};
    logic eol_e [4] = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 8'(i + 1), 8'd0);
      tests++;
      if (out_ii !== ii_e[i] || out_valid !== v_e[i] || out_eol !== eol_e[i] || out_line_valid !== 1'b0) begin
        fails++;
        $display("FAIL fill_%0d: got ii=%0d v=%b eol=%b lv=%b, want ii=%0d v=%b eol=%b lv=0",
                 i, out_ii, out_valid, out_eol, out_line_valid, ii_e[i], v_e[i], eol_e[i]);
      end
      tests++;
      if (o_fill !== (i == 3)) begin
        fails++;
        $display("FAIL fill_flag_%0d: got %b want %b", i, o_fill, i == 3);
      end
    end
    tests++;
    if (out_window !== {8'd6, 8'd10}) begin
      fails++;
      $display("FAIL fill_window: got %h want 060a", out_window);
    end
  endtask
  task automatic test_second_line;
    drive(1'b1, 1'b0, 8'd5, 8'd1);
    tests++;
    if (out_ii !== 8'd6 || out_line_valid !== 1'b1 || out_line_data !== 8'd1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL line2_col0: got ii=%0d lv=%b ld=%0d v=%b, want ii=6 lv=1 ld=1 v=0",
               out_ii, out_line_valid, out_line_data, out_valid);
    end
    drive(1'b1, 1'b0, 8'd6, 8'd3);
    tests++;
    if (out_ii !== 8'd14 || out_line_valid !== 1'b1 || out_line_data !== 8'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL line2_col1: got ii=%0d lv=%b ld=%0d v=%b, want ii=14 lv=1 ld=2 v=1",
               out_ii, out_line_valid, out_line_data, out_valid);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask
  task automatic test_gaps;
    logic [7:0] pix [6] = '{1, 2, 3, 4, 5, 6};
    logic [7:0] abv [6] = '{0, 0, 0, 0, 1, 3};
    logic [7:0] ii_e [6] = '{1, 3, 6, 10, 6, 14};
    logic v_e [6] = '{0, 1, 1, 1, 0, 1};
    logic eol_e [6] = '{0, 0, 0, 1, 0, 0};
    logic lv_e [6] = '{0, 0, 0, 0, 1, 1};
    logic [7:0] ld_e [6] = '{0, 0, 0, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 0, pix[i], abv[i]);
      tests++;
      if (out_ii !== ii_e[i] || out_valid !== v_e[i] || out_eol !== eol_e[i] || out_line_valid !== lv_e[i]
          || (lv_e[i] && out_line_data !== ld_e[i])) begin
        fails++;
        $display("FAIL gaps_%0d: got ii=%0d v=%b eol=%b lv=%b ld=%0d, want ii=%0d v=%b eol=%b lv=%b ld=%0d",
                 i, out_ii, out_valid, out_eol, out_line_valid, out_line_data, ii_e[i], v_e[i], eol_e[i], lv_e[i], ld_e[i]);
      end
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 1'b0, 8'd99, 8'd99);
        tests++;
        if (out_valid !== 1'b0 || out_eol !== 1'b0 || out_line_valid !== 1'b0 || out_ii !== ii_e[i]) begin
          fails++;
          $display("FAIL gaps_idle_%0d_%0d: got v=%b eol=%b lv=%b ii=%0d, want 0 0 0 ii=%0d",
                   i, g, out_valid, out_eol, out_line_valid, out_ii, ii_e[i]);
        end
      end
    end
  endtask
  task automatic test_midline_sof;
    drive(1'b1, 1'b1, 8'd7, 8'd0);
    tests++;
    if (o_fill !== 1'b0 || out_ii !== 8'd7 || out_line_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sof_mid: got fill=%b ii=%0d lv=%b v=%b, want fill=0 ii=7 lv=0 v=0",
               o_fill, out_ii, out_line_valid, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'd1, 8'd0);
      tests++;
      if (out_line_valid !== 1'b0) begin
        fails++;
        $display("FAIL sof_nolv_%0d: got lv=%b want 0", i, out_line_valid);
      end
    end
    drive(1'b1, 1'b0, 8'd2, 8'd0);
    tests++;
    if (out_line_valid !== 1'b1 || out_line_data !== 8'd7 || out_ii !== 8'd2) begin
      fails++;
      $display("FAIL sof_first_pop: got lv=%b ld=%0d ii=%0d, want lv=1 ld=7 ii=2", out_line_valid, out_line_data, out_ii);
    end
  endtask
  task automatic test_overflow;
    drive(1'b1, 1'b1, 8'd200, 8'd0);
    tests++;
    if (out_ii !== 8'd200 || o_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_col0: got ii=%0d ovf=%b want ii=200 ovf=0", out_ii, o_ovf);
    end
    drive(1'b1, 1'b0, 8'd100, 8'd0);
`ifdef ROW_SAT_EN
    tests++;
    if (out_ii !== 8'd255 || o_ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sat: got ii=%0d ovf=%b want ii=255 ovf=1", out_ii, o_ovf);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    tests++;
    if (o_ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_hold: got %b want 1", o_ovf);
    end
    drive(1'b0, 1'b1, 8'd0, 8'd0);
    tests++;
    if (o_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sof_clear: got %b want 0", o_ovf);
    end
`else
    tests++;
    if (out_ii !== 8'd44 || o_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_wrap: got ii=%0d ovf=%b want ii=44 ovf=0", out_ii, o_ovf);
    end
`endif
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask
  task automatic test_reset_midline;
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 8'd3, 8'd0);
    tests++;
    if (o_fill !== 1'b1 || out_line_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_run: got fill=%b lv=%b want 1 1", o_fill, out_line_valid);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_ii, out_window, out_eol, out_line_valid, out_line_data, o_fill, o_ovf} !== '0) begin
      fails++;
      $display("FAIL rst_async: got ii=%0d win=%h v=%b eol=%b lv=%b ld=%0d fill=%b, want all 0",
               out_ii, out_window, out_valid, out_eol, out_line_valid, out_line_data, o_fill);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'd9, 8'd0);
    tests++;
    if (out_ii !== 8'd9 || o_fill !== 1'b0 || out_valid !== 1'b0 || out_line_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_resume: got ii=%0d fill=%b v=%b lv=%b want ii=9 fill=0 v=0 lv=0",
               out_ii, o_fill, out_valid, out_line_valid);
    end
    drive(1'b1, 1'b0, 8'd1, 8'd0);
    tests++;
    if (out_ii !== 8'd10 || out_valid !== 1'b1 || out_window !== {8'd9, 8'd10}) begin
      fails++;
      $display("FAIL rst_col1: got ii=%0d v=%b win=%h want ii=10 v=1 win=090a", out_ii, out_valid, out_window);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask
  initial begin
    test_reset;
    test_fill;
    test_second_line;
    test_gaps;
    test_midline_sof;
    test_overflow;
    test_reset_midline;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
